// File: rtl/program_loader_pkg.sv
// ---------------------------------------------------------------------------
// program_loader_pkg
// Shared definitions for the program loader and its instruction buffer:
// the loader state encoding and the default sizing parameters.
// ---------------------------------------------------------------------------
package program_loader_pkg;

    // Default capacity of the instruction buffer, in 32-bit words.
    localparam int MAX_WORDS_DEFAULT = 32;

    // Default length of the CPU reset pulse issued after a program is loaded.
    localparam int RESTART_CYCLES_DEFAULT = 2;

    // Loader phases, in the order a normal load walks through them.
    typedef enum logic [2:0] {
        COLLECT = 3'd0,
        PREP    = 3'd1,
        STREAM  = 3'd2,
        RESTART = 3'd3,
        RUN     = 3'd4
    } loaderState_t;

endpackage

// File: rtl/program_loader_buffer.sv
// ---------------------------------------------------------------------------
// program_buffer
// MAX_WORDS x 32-bit register file holding the program collected from the
// host. One synchronous write port, one asynchronous read port, and no reset.
// Contents survive Reset and Reload; the loader's word count alone defines
// which entries are valid.
//
// Ports:
//   clk        clock
//   writeEn    write strobe
//   writeAddr  write address
//   writeData  word to store
//   readAddr   read address
//   readData   word at readAddr (combinational)
// ---------------------------------------------------------------------------
module program_buffer
    import program_loader_pkg::*;
#(
    parameter int MAX_WORDS = MAX_WORDS_DEFAULT,
    parameter int ADDR_W    = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1
) (
    input  logic              clk,
    input  logic              writeEn,
    input  logic [ADDR_W-1:0] writeAddr,
    input  logic [31:0]       writeData,
    input  logic [ADDR_W-1:0] readAddr,
    output logic [31:0]       readData
);

    logic [31:0] mem [MAX_WORDS];

    // Storage is deliberately left without a reset so that the whole array
    // can map onto plain registers or distributed RAM.
    always_ff @(posedge clk) begin
        if (writeEn) begin
            mem[writeAddr] <= writeData;
        end
    end

    assign readData = mem[readAddr];

endmodule

// File: rtl/program_loader.sv
// ---------------------------------------------------------------------------
// program_loader
// Collects a program from a host word stream into a local buffer, then holds
// the CPU in reset, streams the buffered words into the CPU's instruction
// memory one per clock, pulses the CPU reset again and lets it run.
//
// Ports:
//   clk              clock, all state changes on the rising edge
//   Reset            asynchronous active-high reset
//   HostValid        host word valid
//   HostData         host instruction word
//   HostLast         marks the final word of the program
//   Reload           request a new program load (honoured only in RUN)
//   HostReady        loader accepts a host word this cycle
//   CpuReset         CPU reset
//   LoadInstructions CPU instruction-load enable
//   Instruction      word presented to the CPU (0 when not loading)
//   Done             program loaded and CPU running
//   WordCount        number of buffered words
//   Overflow         sticky, host sent more than MAX_WORDS words
// ---------------------------------------------------------------------------
module program_loader
    import program_loader_pkg::*;
#(
    parameter int MAX_WORDS      = MAX_WORDS_DEFAULT,
    parameter int RESTART_CYCLES = RESTART_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        HostValid,
    input  logic [31:0] HostData,
    input  logic        HostLast,
    input  logic        Reload,
    output logic        HostReady,
    output logic        CpuReset,
    output logic        LoadInstructions,
    output logic [31:0] Instruction,
    output logic        Done,
    output logic [5:0]  WordCount,
    output logic        Overflow
);

    localparam int ADDR_W = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
    localparam int CNT_W  = 6;
    localparam int RST_W  = (RESTART_CYCLES > 1) ? $clog2(RESTART_CYCLES) : 1;

    loaderState_t     state;
    loaderState_t     nextState;
    logic [CNT_W-1:0] wordCount;
    logic             overflow;
    logic [ADDR_W-1:0] idx;
    logic [RST_W-1:0] restartCount;
    logic [31:0]      readData;

    logic accept;
    logic bufFull;
    logic lastWord;
    logic restartDone;
    logic reloadNow;

    // Only COLLECT takes host words, and that is decided by state alone, so
    // HostReady never depends combinationally on HostValid.
    assign accept      = (state == COLLECT) && HostValid;
    assign bufFull     = (wordCount == CNT_W'(MAX_WORDS));
    assign lastWord    = ((CNT_W'(idx) + CNT_W'(1)) == wordCount);
    assign restartDone = (restartCount == RST_W'(RESTART_CYCLES - 1));
    assign reloadNow   = (state == RUN) && Reload;

    // State register; reset drops straight back to COLLECT, which also pulls
    // LoadInstructions low immediately because the outputs decode from state.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state <= COLLECT;
        end else begin
            state <= nextState;
        end
    end

    // Next-state and output decode. A load always has at least one word:
    // the handshake that ends COLLECT either stores a word or finds the
    // buffer already full, so STREAM never sees an empty program.
    always_comb begin
        nextState        = state;
        HostReady        = 1'b0;
        CpuReset         = 1'b1;
        LoadInstructions = 1'b0;
        Instruction      = 32'h0;
        Done             = 1'b0;
        case (state)
            COLLECT: begin
                HostReady = 1'b1;
                if (accept && HostLast) begin
                    nextState = PREP;
                end
            end
            PREP: begin
                nextState = STREAM;
            end
            STREAM: begin
                CpuReset         = 1'b0;
                LoadInstructions = 1'b1;
                Instruction      = readData;
                if (lastWord) begin
                    nextState = RESTART;
                end
            end
            RESTART: begin
                if (restartDone) begin
                    nextState = RUN;
                end
            end
            RUN: begin
                CpuReset = 1'b0;
                Done     = 1'b1;
                if (Reload) begin
                    nextState = COLLECT;
                end
            end
            default: begin
                nextState = COLLECT;
            end
        endcase
    end

    // Word count and sticky overflow. Words beyond capacity are dropped but
    // still complete the handshake so the host is never stalled.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            wordCount <= '0;
            overflow  <= 1'b0;
        end else if (reloadNow) begin
            wordCount <= '0;
            overflow  <= 1'b0;
        end else if (accept) begin
            if (bufFull) begin
                overflow <= 1'b1;
            end else begin
                wordCount <= wordCount + CNT_W'(1);
            end
        end
    end

    // Stream index and restart pulse counter. Both rest at zero outside
    // their own phase, so each phase starts counting from zero on entry.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            idx          <= '0;
            restartCount <= '0;
        end else begin
            if (state == STREAM && !lastWord) begin
                idx <= idx + ADDR_W'(1);
            end else begin
                idx <= '0;
            end
            if (state == RESTART && !restartDone) begin
                restartCount <= restartCount + RST_W'(1);
            end else begin
                restartCount <= '0;
            end
        end
    end

    program_buffer #(
        .MAX_WORDS (MAX_WORDS),
        .ADDR_W    (ADDR_W)
    ) u_buffer (
        .clk       (clk),
        .writeEn   (accept && !bufFull),
        .writeAddr (wordCount[ADDR_W-1:0]),
        .writeData (HostData),
        .readAddr  (idx),
        .readData  (readData)
    );

    assign WordCount = wordCount;
    assign Overflow  = overflow;

endmodule

// File: tb/tb_program_loader.sv
// ---------------------------------------------------------------------------
// tb_program_loader
// Self-checking bench for program_loader. A transaction-level model builds,
// for each completed program, the timeline of outputs the loader must show
// (one prep cycle, one cycle per buffered word, the restart pulse) and a
// compare process checks every output on every falling edge. Directed tests
// add literal expectations for stream contents, timing and reset behaviour.
// ---------------------------------------------------------------------------
module tb_program_loader;

    localparam int MAXW = 32;
    localparam int RC   = 2;

    logic        clk = 1'b0;
    logic        Reset = 1'b1;
    logic        HostValid = 1'b0;
    logic [31:0] HostData = 32'h0;
    logic        HostLast = 1'b0;
    logic        Reload = 1'b0;
    logic        HostReady;
    logic        CpuReset;
    logic        LoadInstructions;
    logic [31:0] Instruction;
    logic        Done;
    logic [5:0]  WordCount;
    logic        Overflow;

    int compared   = 0;
    int mismatched = 0;
    bit checking   = 1'b0;

    always #5 clk = ~clk;

    program_loader #(
        .MAX_WORDS      (MAXW),
        .RESTART_CYCLES (RC)
    ) dut (
        .clk              (clk),
        .Reset            (Reset),
        .HostValid        (HostValid),
        .HostData         (HostData),
        .HostLast         (HostLast),
        .Reload           (Reload),
        .HostReady        (HostReady),
        .CpuReset         (CpuReset),
        .LoadInstructions (LoadInstructions),
        .Instruction      (Instruction),
        .Done             (Done),
        .WordCount        (WordCount),
        .Overflow         (Overflow)
    );

    task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // ---------------- transaction-level model ----------------
    typedef struct {
        logic        cpuReset;
        logic        load;
        logic [31:0] instr;
    } slot_t;

    slot_t       schedule[$];
    logic [31:0] mWords[$];
    bit          mOverflow   = 1'b0;
    bit          mCollecting = 1'b1;

    function automatic slot_t mkSlot(input logic cr, input logic ld, input logic [31:0] ins);
        slot_t s;
        s.cpuReset = cr;
        s.load     = ld;
        s.instr    = ins;
        return s;
    endfunction

    always @(posedge clk or posedge Reset) begin
        if (Reset) begin
            mWords.delete();
            schedule.delete();
            mOverflow   = 1'b0;
            mCollecting = 1'b1;
        end else if (schedule.size() > 0) begin
            void'(schedule.pop_front());
        end else if (mCollecting) begin
            if (HostValid) begin
                if (mWords.size() < MAXW) mWords.push_back(HostData);
                else mOverflow = 1'b1;
                if (HostLast) begin
                    mCollecting = 1'b0;
                    schedule.push_back(mkSlot(1'b1, 1'b0, 32'h0));
                    foreach (mWords[i]) schedule.push_back(mkSlot(1'b0, 1'b1, mWords[i]));
                    for (int i = 0; i < RC; i++) schedule.push_back(mkSlot(1'b1, 1'b0, 32'h0));
                end
            end
        end else if (Reload) begin
            mWords.delete();
            mOverflow   = 1'b0;
            mCollecting = 1'b1;
        end
    end

    task automatic checkOutput();
        logic        eHR, eCR, eLd, eDone;
        logic [31:0] eIn;
        if (schedule.size() > 0) begin
            eHR = 1'b0; eCR = schedule[0].cpuReset; eLd = schedule[0].load;
            eIn = schedule[0].instr; eDone = 1'b0;
        end else if (mCollecting) begin
            eHR = 1'b1; eCR = 1'b1; eLd = 1'b0; eIn = 32'h0; eDone = 1'b0;
        end else begin
            eHR = 1'b0; eCR = 1'b0; eLd = 1'b0; eIn = 32'h0; eDone = 1'b1;
        end
        checkValue("cyc HostReady", {31'b0, HostReady}, {31'b0, eHR});
        checkValue("cyc CpuReset", {31'b0, CpuReset}, {31'b0, eCR});
        checkValue("cyc LoadInstructions", {31'b0, LoadInstructions}, {31'b0, eLd});
        checkValue("cyc Instruction", Instruction, eIn);
        checkValue("cyc Done", {31'b0, Done}, {31'b0, eDone});
        checkValue("cyc WordCount", {26'b0, WordCount}, mWords.size());
        checkValue("cyc Overflow", {31'b0, Overflow}, {31'b0, mOverflow});
    endtask

    always @(negedge clk) begin
        if (checking) checkOutput();
    end

    // ---------------- stream monitor ----------------
    logic        prevCpuReset = 1'b1;
    int          sinceFall = 0;
    int          busyCycles = 0;
    logic [31:0] seen[$];
    int          seenPos[$];

    always @(negedge clk) begin
        if (prevCpuReset && !CpuReset) sinceFall = 0;
        else sinceFall++;
        if (LoadInstructions) begin
            seen.push_back(Instruction);
            seenPos.push_back(sinceFall);
        end
        if (CpuReset && !HostReady) busyCycles++;
        prevCpuReset = CpuReset;
    end

    // ---------------- stimulus ----------------
    task automatic applyStimulus(input logic v, input logic [31:0] d, input logic l, input logic r);
        @(negedge clk);
        HostValid = v;
        HostData  = d;
        HostLast  = l;
        Reload    = r;
    endtask

    task automatic sendProgram(input logic [31:0] words[$], input bit gaps);
        for (int i = 0; i < words.size(); i++) begin
            applyStimulus(1'b1, words[i], (i == words.size() - 1), 1'b0);
            if (gaps) applyStimulus(1'b0, 32'hDEADBEEF, (i != words.size() - 1), 1'b0);
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic waitDone(input string name, input int budget);
        int n = 0;
        while (Done !== 1'b1 && n < budget) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
            n++;
        end
        checkValue({name, " Done reached"}, {31'b0, Done}, 32'd1);
    endtask

    task automatic checkStream(input string name, input logic [31:0] words[$]);
        checkValue({name, " stream length"}, seen.size(), words.size());
        for (int i = 0; i < words.size(); i++) begin
            if (i < seen.size()) begin
                checkValue({name, " stream word"}, seen[i], words[i]);
                checkValue({name, " stream clock"}, seenPos[i], i);
            end
        end
    endtask

    task automatic clearMonitor();
        seen.delete();
        seenPos.delete();
        busyCycles = 0;
    endtask

    task automatic pulseReload();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] progA[$];
        logic [31:0] progB[$];
        logic [31:0] progC[$];
        logic [31:0] progC32[$];
        logic [31:0] progD[$];
        logic [31:0] progE[$];
        bit found;

        progA = '{32'h20010005, 32'h20020003, 32'h00221820};
        progB = '{32'hA0000001, 32'hA0000002, 32'hA0000003, 32'hA0000004};
        for (int i = 1; i <= 34; i++) progC.push_back(32'h10000000 + i);
        for (int i = 1; i <= 32; i++) progC32.push_back(32'h10000000 + i);
        progD = '{32'h8C220004};
        for (int i = 0; i < 10; i++) progE.push_back(32'h55000000 + i * 16);

        // Reset state.
        @(negedge clk);
        checking = 1'b1;
        checkValue("reset HostReady", {31'b0, HostReady}, 32'd1);
        checkValue("reset CpuReset", {31'b0, CpuReset}, 32'd1);
        checkValue("reset LoadInstructions", {31'b0, LoadInstructions}, 32'd0);
        checkValue("reset WordCount", {26'b0, WordCount}, 32'd0);
        @(negedge clk);
        Reset = 1'b0;

        // Three-word program; a Reload in COLLECT must be ignored.
        clearMonitor();
        pulseReload();
        sendProgram(progA, 1'b0);
        waitDone("prog3", 40);
        checkStream("prog3", progA);
        checkValue("prog3 first word", (seen.size() > 0) ? seen[0] : 32'h0, 32'h20010005);
        checkValue("prog3 prep+restart cycles", busyCycles, 32'd3);

        // Host words in RUN are ignored; Reload returns to COLLECT.
        applyStimulus(1'b1, 32'hCAFEF00D, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'hCAFEF00E, 1'b0, 1'b0);
        checkValue("run HostReady", {31'b0, HostReady}, 32'd0);
        checkValue("run WordCount", {26'b0, WordCount}, 32'd3);
        pulseReload();
        checkValue("reload Done", {31'b0, Done}, 32'd0);
        checkValue("reload CpuReset", {31'b0, CpuReset}, 32'd1);
        checkValue("reload WordCount", {26'b0, WordCount}, 32'd0);

        // Four words with HostValid toggling; gaps carry a stray HostLast.
        clearMonitor();
        sendProgram(progB, 1'b1);
        waitDone("toggle", 40);
        checkStream("toggle", progB);
        pulseReload();

        // Overflow: 34 words into a 32-word buffer.
        clearMonitor();
        sendProgram(progC, 1'b0);
        waitDone("ovf", 100);
        checkValue("ovf Overflow", {31'b0, Overflow}, 32'd1);
        checkValue("ovf WordCount", {26'b0, WordCount}, 32'd32);
        checkStream("ovf", progC32);
        pulseReload();
        checkValue("ovf cleared", {31'b0, Overflow}, 32'd0);

        // Single-word program.
        clearMonitor();
        sendProgram(progD, 1'b0);
        waitDone("single", 20);
        checkStream("single", progD);
        checkValue("single prep+restart cycles", busyCycles, 32'd3);
        pulseReload();

        // Reset in the middle of streaming, then a full reload.
        clearMonitor();
        sendProgram(progE, 1'b0);
        found = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            @(negedge clk);
            #1;
            if (LoadInstructions === 1'b1 && Instruction === progE[5]) found = 1'b1;
        end
        checkValue("abort reached idx5", {31'b0, found}, 32'd1);
        Reset = 1'b1;
        #1;
        checkValue("abort LoadInstructions", {31'b0, LoadInstructions}, 32'd0);
        checkValue("abort Instruction", Instruction, 32'd0);
        checkValue("abort CpuReset", {31'b0, CpuReset}, 32'd1);
        checkValue("abort HostReady", {31'b0, HostReady}, 32'd1);
        checkValue("abort WordCount", {26'b0, WordCount}, 32'd0);
        @(negedge clk);
        Reset = 1'b0;
        clearMonitor();
        sendProgram(progE, 1'b0);
        waitDone("reload10", 40);
        checkStream("reload10", progE);

        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        checking = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter: MAX_WORDS, default 32, instruction-memory capacity in words.
REQ-002 Parameter: RESTART_CYCLES, default 2, length of the post-load CPU reset pulse.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: Reset  input  1  asynchronous, active-high reset.
REQ-005 Port: HostValid  input  1  host word valid.
REQ-006 Port: HostData  input  32  host instruction word.
REQ-007 Port: HostLast  input  1  marks final word of the program.
REQ-008 Port: Reload  input  1  one-cycle request to load a new program (honoured in RUN only).
REQ-009 Port: HostReady  output  1  loader accepts a host word this cycle.
REQ-010 Port: CpuReset  output  1  drives the CPU Reset input.
REQ-011 Port: LoadInstructions  output  1  drives the CPU LoadInstructions input.
REQ-012 Port: Instruction  output  32  drives the CPU Instruction input.
REQ-013 Port: Done  output  1  program loaded and CPU running.
REQ-014 Port: WordCount  output  6  number of buffered words, 0..MAX_WORDS.
REQ-015 Port: Overflow  output  1  sticky; host sent more than MAX_WORDS words.

Function
REQ-016 States SHALL be COLLECT, PREP, STREAM, RESTART, RUN; all outputs decode from registered state, counters and buffer only (no input-to-output combinational path).
REQ-017 COLLECT: HostReady=1, CpuReset=1, LoadInstructions=0; on HostValid&HostReady with WordCount<MAX_WORDS, write HostData to buf[WordCount] and increment WordCount.
REQ-018 COLLECT with WordCount==MAX_WORDS: accepted words SHALL be discarded, WordCount held, Overflow set to 1.
REQ-019 Handshake with HostLast=1 SHALL move COLLECT->PREP; HostLast without HostValid SHALL be ignored.
REQ-020 PREP: exactly 1 cycle, HostReady=0, CpuReset=1, then ->STREAM.
REQ-021 STREAM: CpuReset=0, LoadInstructions=1, Instruction=buf[idx], idx=0 on entry, incremented every cycle, no gaps; ->RESTART after the cycle with idx==WordCount-1 (STREAM lasts exactly WordCount cycles).
REQ-022 Word k SHALL be presented on the k-th clock after CpuReset falls, matching the CPU load counter that clears on Reset and counts every clock.
REQ-023 RESTART: CpuReset=1, LoadInstructions=0, Instruction=0, for RESTART_CYCLES cycles, then ->RUN.
REQ-024 RUN: CpuReset=0, Done=1, HostReady=0; host words ignored.
REQ-025 Reload in RUN SHALL clear WordCount, idx, Done and Overflow, and move to COLLECT; Reload in any other state SHALL be ignored.
REQ-026 Instruction SHALL be 0 whenever LoadInstructions=0.
REQ-027 Buffer contents SHALL NOT be cleared on Reset or Reload; only WordCount defines valid words.

Reset
REQ-028 Reset asserted SHALL immediately force COLLECT, CpuReset=1, HostReady=1, LoadInstructions=0, Instruction=0, Done=0, WordCount=0, Overflow=0, idx=0, restart counter=0.
REQ-029 Reset mid-STREAM SHALL abort the load within the same cycle; LoadInstructions SHALL deassert asynchronously.

Structure
REQ-030 State encoding and MAX_WORDS/RESTART_CYCLES defaults SHALL live in the shared CPU package.
REQ-031 Buffer SHALL be one sub-module, program_buffer (MAX_WORDS x 32 registers, one write port, one asynchronous read port, no reset).

Verification
REQ-032 3 words 0x20010005, 0x20020003, 0x00221820 (last on word 3) -> PREP 1 cycle, STREAM 3 cycles in order on clocks 0,1,2 after CpuReset fall, RESTART 2 cycles, Done=1.
REQ-033 HostValid toggling 1,0,1,0 with 4 words -> WordCount steps 1..4, no word lost or duplicated in STREAM.
REQ-034 34 words, last on word 34 -> Overflow=1, WordCount=32, STREAM exactly 32 cycles carrying words 1..32.
REQ-035 Single-word program, HostLast on word 1 -> STREAM exactly 1 cycle with that word, then RESTART, then RUN.
REQ-036 Reset asserted at STREAM idx=5 of 10 -> outputs at reset values that cycle; reload of 10 words then streams from idx 0.
REQ-037 In RUN, HostValid with data -> ignored, HostReady=0; Reload pulse -> COLLECT, Done=0, CpuReset=1, WordCount=0.
